// File: rtl/pattern_seq_pkg.sv
// ============================================================================
// Module  : pattern_seq_pkg
// Brief   : Shared state encoding and defaults for the pattern sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pattern_seq_pkg;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 2;
  localparam int unsigned LED_SEL_RST = 1;

  typedef enum logic [1:0] {
    ST_COPY      = 2'd0,
    ST_PLAY_WAIT = 2'd1,
    ST_PLAY_RD   = 2'd2,
    ST_PLAY_LOAD = 2'd3
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_timer.sv
// ============================================================================
// Module  : dwell_timer
// Brief   : Counts tick strobes; done pulses with the DWELL_TICKS-th tick.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dwell_timer
  import pattern_seq_pkg::*;
#(
  parameter int unsigned DWELL_TICKS = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic clr_i,
  output logic done_o
);

  localparam int unsigned CW = clog2_min1(DWELL_TICKS);
  localparam logic [CW-1:0] LAST = CW'(DWELL_TICKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // done is combinational so the caller can react in the tick's own cycle.
  always_comb begin
    cnt_d  = cnt_q;
    done_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pattern_seq_ctrl.sv
// ============================================================================
// Module  : pattern_seq_ctrl
// Brief   : Copies the pattern ROM into RAM after reset, then plays RAM back
//           to the led driver one entry per dwell period.
//           Optional macro PATTERN_RELOAD_EN adds reload_req_i (re-copy).
// Revision: 1.0
// ============================================================================
`default_nettype none

module pattern_seq_ctrl
  import pattern_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned PAT_LEN     = 7,
  parameter int unsigned DWELL_TICKS = 6,
  parameter int unsigned RAM_RD_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1s_i,
`ifdef PATTERN_RELOAD_EN
  input  logic              reload_req_i,
`endif
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_dout_i,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic              ram_oce_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic [DATA_W-1:0] led_sel_o,
  output logic              led_load_en_o,
  output logic              copy_done_o
);

  // One counter serves both the copy index (0..PAT_LEN) and the read wait.
  localparam int unsigned CNT_W =
    ((ADDR_W + 1) > clog2_min1(RAM_RD_LAT + 1)) ? (ADDR_W + 1) : clog2_min1(RAM_RD_LAT + 1);
  localparam logic [CNT_W-1:0]  COPY_LAST = CNT_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(RAM_RD_LAT - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(PAT_LEN - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                copy_done_q, copy_done_d;
  logic [DATA_W-1:0]   led_sel_q, led_sel_d;
  logic                led_load_q, led_load_d;
  logic                dwell_clr;
  logic                dwell_done;

  dwell_timer #(
    .DWELL_TICKS (DWELL_TICKS)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (tick_1s_i),
    .clr_i  (dwell_clr),
    .done_o (dwell_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_COPY;
      cnt_q       <= '0;
      ptr_q       <= '0;
      copy_done_q <= 1'b0;
      led_sel_q   <= DATA_W'(LED_SEL_RST);
      led_load_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      copy_done_q <= copy_done_d;
      led_sel_q   <= led_sel_d;
      led_load_q  <= led_load_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    copy_done_d = copy_done_q;
    led_sel_d   = led_sel_q;
    led_load_d  = 1'b0;
    dwell_clr   = 1'b0;
    rom_addr_o  = '0;
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_oce_o   = 1'b0;
    ram_addr_o  = '0;
    ram_din_o   = '0;

    unique case (state_q)
      ST_COPY: begin
        dwell_clr  = 1'b1;
        rom_addr_o = cnt_q[ADDR_W-1:0];
        // ROM data arrives a cycle after its address, so writes trail by one.
        if (cnt_q != '0) begin
          ram_ce_o   = 1'b1;
          ram_we_o   = 1'b1;
          ram_addr_o = ADDR_W'(cnt_q - 1'b1);
          ram_din_o  = rom_dout_i;
        end
        if (cnt_q == COPY_LAST) begin
          state_d     = ST_PLAY_WAIT;
          cnt_d       = '0;
          copy_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PLAY_WAIT: begin
        if (dwell_done) begin
          state_d = ST_PLAY_RD;
          cnt_d   = '0;
        end
      end
      ST_PLAY_RD: begin
        ram_ce_o   = 1'b1;
        ram_oce_o  = 1'b1;
        ram_addr_o = ptr_q;
        if (cnt_q == RD_LAST) begin
          state_d = ST_PLAY_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PLAY_LOAD: begin
        led_sel_d  = ram_dout_i;
        led_load_d = 1'b1;
        ptr_d      = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        state_d    = ST_PLAY_WAIT;
      end
      default: state_d = ST_COPY;
    endcase

`ifdef PATTERN_RELOAD_EN
    // Abort wins over whatever the playback state decided this cycle.
    if (reload_req_i && (state_q != ST_COPY)) begin
      state_d     = ST_COPY;
      cnt_d       = '0;
      ptr_d       = '0;
      copy_done_d = 1'b0;
      led_sel_d   = led_sel_q;
      led_load_d  = 1'b0;
      dwell_clr   = 1'b1;
    end
`endif
  end

  assign led_sel_o     = led_sel_q;
  assign led_load_en_o = led_load_q;
  assign copy_done_o   = copy_done_q;

endmodule

`default_nettype wire
